// File: rtl/seg7_pkg.sv
// Shared glyph table, FSM state type and per-digit decode result for seg7_reader.
package seg7_pkg;

  // Active-low segment patterns, bit0=a .. bit6=g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    SETTLE      = 2'd0,
    CAPTURE     = 2'd1,
    PRESENT     = 2'd2,
    WAIT_CHANGE = 2'd3
  } seg7_state_t;

  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       err;
  } seg7_dec_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational lookup of one active-low 7-segment pattern into {nibble, blank, err}.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output seg7_dec_t  res
);

  always_comb begin
    res.nibble = 4'h0;
    res.blank  = 1'b0;
    res.err    = 1'b0;
    case (seg)
      SEG_0:     res.nibble = 4'h0;
      SEG_1:     res.nibble = 4'h1;
      SEG_2:     res.nibble = 4'h2;
      SEG_3:     res.nibble = 4'h3;
      SEG_4:     res.nibble = 4'h4;
      SEG_5:     res.nibble = 4'h5;
      SEG_6:     res.nibble = 4'h6;
      SEG_7:     res.nibble = 4'h7;
      SEG_8:     res.nibble = 4'h8;
      SEG_9:     res.nibble = 4'h9;
      SEG_A:     res.nibble = 4'hA;
      SEG_B:     res.nibble = 4'hB;
      SEG_C:     res.nibble = 4'hC;
      SEG_D:     res.nibble = 4'hD;
      SEG_E:     res.nibble = 4'hE;
      SEG_BLANK: begin
        res.nibble = 4'hF;
        res.blank  = 1'b1;
      end
      default:   res.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Reads back active-low 7-segment drive lines, waits for them to settle and presents decoded hex digits
// on a valid/ready handshake. Define SEG7_READER_ERRCNT_EN to build the saturating invalid-capture counter.
//
// state       | meaning
// SETTLE      | counting consecutive unchanged input cycles
// CAPTURE     | snapshot input, register decoded word
// PRESENT     | out_valid high, outputs frozen until out_ready
// WAIT_CHANGE | word consumed, waiting for input to differ from snapshot
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] out_val,
  output logic [NUM_DIGITS-1:0]   out_blank,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic [7:0]              err_cnt
);

  localparam int SW = 7 * NUM_DIGITS;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TARGET = CW'(STABLE_CYCLES);

  logic [SW-1:0]           s_q;
  logic [SW-1:0]           snap;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_nxt;
  logic                    restart;
  logic                    clear_cnt;
  seg7_state_t             state;
  seg7_state_t             state_nxt;
  seg7_dec_t               dec [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] dec_val;
  logic [NUM_DIGITS-1:0]   dec_blank;
  logic [NUM_DIGITS-1:0]   dec_err;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    seg7_decode u_dec (
      .seg (s_q[7*i +: 7]),
      .res (dec[i])
    );
  end

  always_comb begin
    dec_val   = '0;
    dec_blank = '0;
    dec_err   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dec_val[4*i +: 4] = dec[i].nibble;
      dec_blank[i]      = dec[i].blank;
      dec_err[i]        = dec[i].err;
    end
  end

  // The cycle after leaving WAIT_CHANGE is held at zero so the count restarts from the cycle the change was seen
  always_comb begin
    cnt_nxt = '0;
    if (!restart && (seg_in == s_q)) begin
      cnt_nxt = (cnt == CNT_TARGET) ? cnt : cnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    clear_cnt = 1'b0;
    case (state)
      SETTLE: begin
        if (cnt_nxt == CNT_TARGET) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        state_nxt = PRESENT;
      end
      PRESENT: begin
        if (out_ready) state_nxt = WAIT_CHANGE;
      end
      WAIT_CHANGE: begin
        if (s_q != snap) begin
          state_nxt = SETTLE;
          clear_cnt = 1'b1;
        end
      end
      default: state_nxt = SETTLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SETTLE;
      s_q       <= '1;
      cnt       <= '0;
      restart   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      s_q       <= seg_in;
      cnt       <= clear_cnt ? '0 : cnt_nxt;
      restart   <= clear_cnt;
      out_valid <= (state_nxt == PRESENT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap      <= '1;
      out_val   <= '0;
      out_blank <= '0;
      out_err   <= '0;
    end else if (state == CAPTURE) begin
      snap      <= s_q;
      out_val   <= dec_val;
      out_blank <= dec_blank;
      out_err   <= dec_err;
    end
  end

`ifdef SEG7_READER_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'h00;
    end else if ((state == CAPTURE) && (|dec_err) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// Directed scoreboard bench for seg7_reader: latency, freeze, decode, glitch rejection, err_cnt and reset.
module tb_seg7_reader;

  localparam int N  = 6;
  localparam int S  = 16;
  localparam int HP = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           out_ready = 1'b0;
  logic [7*N-1:0] seg_in;
  logic           out_valid;
  logic [4*N-1:0] out_val;
  logic [N-1:0]   out_blank;
  logic [N-1:0]   out_err;
  logic [7:0]     err_cnt;

  seg7_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_blank (out_blank),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #HP clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [4*N-1:0] val;
    logic [N-1:0]   blank;
    logic [N-1:0]   err;
    logic [7:0]     ec;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   words = 0;
  int   ec_model = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [7:0] ec_exp();
`ifdef SEG7_READER_ERRCNT_EN
    return 8'(ec_model);
`else
    return 8'h00;
`endif
  endfunction

  task automatic bump_ec();
    if (ec_model < 255) ec_model++;
  endtask

  task automatic push(input logic [4*N-1:0] v, input logic [N-1:0] b, input logic [N-1:0] r);
    e.val   = v;
    e.blank = b;
    e.err   = r;
    e.ec    = ec_exp();
    sb.push_back(e);
  endtask

  // Scoreboard: every rising out_valid must match the oldest expected word
  always @(negedge clk) begin
    if (out_valid && !prev_valid) begin
      words <= words + 1;
      if (sb.size() == 0) begin
        chk("unexpected_word", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("word_val", 64'(out_val), 64'(mon_e.val));
        chk("word_blank", 64'(out_blank), 64'(mon_e.blank));
        chk("word_err", 64'(out_err), 64'(mon_e.err));
        chk("word_err_cnt", 64'(err_cnt), 64'(mon_e.ec));
      end
    end
    prev_valid <= out_valid;
  end

  task automatic wait_valid(output int at);
    int n;
    n  = 0;
    at = -1;
    while (!out_valid && n < 4*S + 20) begin
      @(negedge clk);
      n++;
    end
    if (out_valid) at = cyc;
    else chk("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic handshake(output int h);
    out_ready = 1'b1;
    @(negedge clk);
    chk("hs_valid_drop", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    h = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, rise, h, w0;

    for (int i = 0; i < N; i++) seg_in[7*i +: 7] = glyph(i);
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_val", 64'(out_val), 64'd0);
    chk("rst_blank", 64'(out_blank), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);

    // Word 0..5 from reset release
    push(24'h543210, 6'b0, 6'b0);
    rst_n = 1'b1;
    c0 = cyc;
    wait_valid(rise);
    chk("reset_latency", 64'(rise), 64'(c0 + S + 2));

    // Input changes while the word is held and not accepted
    for (int i = 0; i < N; i++) seg_in[7*i +: 7] = glyph(6 + i);
    push(24'hBA9876, 6'b0, 6'b0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_val", 64'(out_val), 64'h543210);
    end
    handshake(h);
    wait_valid(rise);
    chk("rearm_latency", 64'(rise), 64'(h + S + 3));
    handshake(h);

    // Blank and invalid digits
    seg_in[6:0]  = 7'h7F;
    seg_in[13:7] = 7'h0E;
    for (int i = 2; i < N; i++) seg_in[7*i +: 7] = 7'h08;
    bump_ec();
    push(24'hAAAA0F, 6'b000001, 6'b000010);
    wait_valid(rise);
    handshake(h);

    // Glitches shorter than the stability window produce nothing
    w0 = words;
    for (int k = 1; k <= 10; k++) begin
      seg_in[6:0] = (k % 2 == 1) ? 7'h40 : 7'h79;
      repeat (S - 1) @(negedge clk);
    end
    chk("glitch_no_word", 64'(words), 64'(w0));
    chk("glitch_valid_low", 64'(out_valid), 64'd0);
    bump_ec();
    push(24'hAAAA01, 6'b0, 6'b000010);
    wait_valid(rise);
    handshake(h);
    repeat (4*S) @(negedge clk);
    chk("no_repeat_word", 64'(words), 64'(w0 + 1));
    chk("no_repeat_valid", 64'(out_valid), 64'd0);

    // Drive err_cnt past saturation
    for (int i = 0; i < 300; i++) begin
      seg_in[13:7] = (i % 2 == 0) ? 7'h0F : 7'h0E;
      bump_ec();
      push(24'hAAAA01, 6'b0, 6'b000010);
      wait_valid(rise);
      handshake(h);
    end
    chk("err_cnt_sat", 64'(err_cnt), 64'(ec_exp()));

    // Asynchronous reset while a word is presented
    seg_in[13:7] = 7'h0F;
    bump_ec();
    push(24'hAAAA01, 6'b0, 6'b000010);
    wait_valid(rise);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("async_rst_val", 64'(out_val), 64'd0);
    @(negedge clk);
    ec_model = 0;
    bump_ec();
    push(24'hAAAA01, 6'b0, 6'b000010);
    rst_n = 1'b1;
    c0 = cyc;
    wait_valid(rise);
    chk("post_reset_latency", 64'(rise), 64'(c0 + S + 2));
    @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
